jtag_tap_core: RTL and testbench

Parametrised IEEE 1149.1 TAP core: 16-state TAP controller plus instruction register, IR decoder, built-in BYPASS and IDCODE data registers, and a TDO multiplexer with a selectable bank of user data registers. It is the JTAG front end for the design and replaces the bare state-machine controller. User logic sees only one-hot selects and DR strobes, and returns one serial bit per user register.

---
 rtl/jtag_pkg.sv | 30 +++
 rtl/jtag_tap_fsm.sv | 46 ++++
 rtl/jtag_tap_core.sv | 161 ++++++++++++++++
 tb/tb_jtag_tap_core.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: controller state encodings and default opcode constants.
package jtag_pkg;

  typedef enum logic [3:0] {
    StEx2Dr   = 4'h0,
    StEx1Dr   = 4'h1,
    StShDr    = 4'h2,
    StPauseDr = 4'h3,
    StSelIr   = 4'h4,
    StUpdDr   = 4'h5,
    StCapDr   = 4'h6,
    StSelDr   = 4'h7,
    StEx2Ir   = 4'h8,
    StEx1Ir   = 4'h9,
    StShIr    = 4'hA,
    StPauseIr = 4'hB,
    StRti     = 4'hC,
    StUpdIr   = 4'hD,
    StCapIr   = 4'hE,
    StTlr     = 4'hF
  } tap_state_e;

  localparam int unsigned IrWidthDefault  = 4;
  localparam int unsigned NumUserDefault  = 4;
  localparam int unsigned IdcodeWidth     = 32;
  localparam logic [31:0] IdcodeDefault   = 32'h0A5C_3001;
  localparam logic [3:0]  IrIdcodeDefault = 4'h1;
  localparam logic [3:0]  UserBaseDefault = 4'h8;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller: state register and next-state logic only.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck_i,
  input  logic       trst_i,
  input  logic       tms_i,
  output tap_state_e state_o
);

  tap_state_e state_q, state_d;

  always_ff @(posedge tck_i or posedge trst_i) begin
    if (trst_i) begin
      state_q <= StTlr;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StTlr;
    case (state_q)
      StTlr:     state_d = tms_i ? StTlr     : StRti;
      StRti:     state_d = tms_i ? StSelDr   : StRti;
      StSelDr:   state_d = tms_i ? StSelIr   : StCapDr;
      StCapDr:   state_d = tms_i ? StEx1Dr   : StShDr;
      StShDr:    state_d = tms_i ? StEx1Dr   : StShDr;
      StEx1Dr:   state_d = tms_i ? StUpdDr   : StPauseDr;
      StPauseDr: state_d = tms_i ? StEx2Dr   : StPauseDr;
      StEx2Dr:   state_d = tms_i ? StUpdDr   : StShDr;
      StUpdDr:   state_d = tms_i ? StSelDr   : StRti;
      StSelIr:   state_d = tms_i ? StTlr     : StCapIr;
      StCapIr:   state_d = tms_i ? StEx1Ir   : StShIr;
      StShIr:    state_d = tms_i ? StEx1Ir   : StShIr;
      StEx1Ir:   state_d = tms_i ? StUpdIr   : StPauseIr;
      StPauseIr: state_d = tms_i ? StEx2Ir   : StPauseIr;
      StEx2Ir:   state_d = tms_i ? StUpdIr   : StShIr;
      StUpdIr:   state_d = tms_i ? StSelDr   : StRti;
      default:   state_d = StTlr;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_core.sv
// JTAG TAP front end: controller, instruction register and decode, BYPASS/IDCODE registers,
// user register selects/strobes, and the negedge-registered TDO path.
module jtag_tap_core
  import jtag_pkg::*;
#(
  parameter int unsigned            IR_WIDTH     = IrWidthDefault,
  parameter logic [31:0]            IDCODE_VALUE = IdcodeDefault,
  parameter logic [IR_WIDTH-1:0]    IR_IDCODE    = IR_WIDTH'(IrIdcodeDefault),
  parameter logic [IR_WIDTH-1:0]    USER_BASE    = IR_WIDTH'(UserBaseDefault),
  parameter int unsigned            NUM_USER     = NumUserDefault
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  input  logic [NUM_USER-1:0] user_tdo,
  output logic [NUM_USER-1:0] user_sel,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic                tap_rst,
  output logic [IR_WIDTH-1:0] ir_value,
  output logic [3:0]          tap_state
);

  // Opcode map sanity: IDCODE, the user range and the all-ones BYPASS code must not overlap.
  localparam int unsigned UserFirst = 32'(USER_BASE);
  localparam int unsigned UserLast  = UserFirst + NUM_USER - 1;
  localparam int unsigned IrAllOnes = (32'd1 << IR_WIDTH) - 1;
  localparam int unsigned IdcodeOp  = 32'(IR_IDCODE);

  if (IR_WIDTH < 2 || NUM_USER < 1 || !IDCODE_VALUE[0]) begin : g_bad_params
    $error("jtag_tap_core: illegal IR_WIDTH, NUM_USER or IDCODE_VALUE");
  end

  if ((IdcodeOp >= UserFirst && IdcodeOp <= UserLast) || UserLast >= IrAllOnes ||
      IdcodeOp == IrAllOnes) begin : g_opcode_collision
    $error("jtag_tap_core: opcode collision between IDCODE, user range and BYPASS");
  end

  tap_state_e state;

  jtag_tap_fsm u_fsm (
    .tck_i   (TCK),
    .trst_i  (TRST),
    .tms_i   (TMS),
    .state_o (state)
  );

  logic [IR_WIDTH-1:0]    ir_shift_q;
  logic [IR_WIDTH-1:0]    ir_q;
  logic                   bypass_q;
  logic [IdcodeWidth-1:0] idcode_q;
  logic                   tdo_q, tdo_en_q;
  logic                   tdo_d, tdo_en_d;
  logic                   idcode_sel, bypass_sel;
  logic [NUM_USER-1:0]    user_hit;

  // IR shift register: capture the mandatory 01 pattern, shift LSB-first.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_shift_q <= '0;
    end else if (state == StCapIr) begin
      ir_shift_q <= IR_WIDTH'(1);
    end else if (state == StShIr) begin
      ir_shift_q <= {TDI, ir_shift_q[IR_WIDTH-1:1]};
    end
  end

  // Active IR changes on the falling edge so decode is stable for the next rising edge.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_q <= IR_IDCODE;
    end else if (state == StTlr) begin
      ir_q <= IR_IDCODE;
    end else if (state == StUpdIr) begin
      ir_q <= ir_shift_q;
    end
  end

  always_comb begin
    user_hit = '0;
    for (int unsigned i = 0; i < NUM_USER; i++) begin
      if (ir_q == USER_BASE + IR_WIDTH'(i)) begin
        user_hit[i] = 1'b1;
      end
    end
  end

  assign idcode_sel = (ir_q == IR_IDCODE);
  assign bypass_sel = !idcode_sel && (user_hit == '0);

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      bypass_q <= 1'b0;
    end else if (bypass_sel) begin
      if (state == StCapDr) begin
        bypass_q <= 1'b0;
      end else if (state == StShDr) begin
        bypass_q <= TDI;
      end
    end
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      idcode_q <= IDCODE_VALUE;
    end else if (idcode_sel) begin
      if (state == StCapDr) begin
        idcode_q <= IDCODE_VALUE;
      end else if (state == StShDr) begin
        idcode_q <= {TDI, idcode_q[IdcodeWidth-1:1]};
      end
    end
  end

  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    case (state)
      StShIr: begin
        tdo_d    = ir_shift_q[0];
        tdo_en_d = 1'b1;
      end
      StShDr: begin
        tdo_en_d = 1'b1;
        if (idcode_sel) begin
          tdo_d = idcode_q[0];
        end else if (bypass_sel) begin
          tdo_d = bypass_q;
        end else begin
          tdo_d = |(user_hit & user_tdo);
        end
      end
      default: ;
    endcase
  end

  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign TDO        = tdo_q;
  assign TDO_EN     = tdo_en_q;
  assign user_sel   = user_hit;
  assign capture_dr = (state == StCapDr);
  assign shift_dr   = (state == StShDr);
  assign update_dr  = (state == StUpdDr);
  assign tap_rst    = (state == StTlr);
  assign ir_value   = ir_q;
  assign tap_state  = state;

endmodule

// File: tb/tb_jtag_tap_core.sv
// Self-checking bench for jtag_tap_core: directed scenarios plus a random TMS/TDI walk
// checked against a table-driven behavioural TAP model.
module tb_jtag_tap_core;

  localparam logic [31:0] IDCODE = 32'h0A5C_3001;

  // Next-state tables indexed by the state code, one per TMS value.
  localparam logic [3:0] NXT0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                                       4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
  localparam logic [3:0] NXT1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                                       4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

  logic       TCK = 1'b0;
  logic       TRST = 1'b1;
  logic       TMS = 1'b1;
  logic       TDI = 1'b0;
  logic       TDO, TDO_EN;
  logic [3:0] user_tdo = 4'h0;
  logic [3:0] user_sel;
  logic       capture_dr, shift_dr, update_dr, tap_rst;
  logic [3:0] ir_value, tap_state;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state
  logic [3:0]  m_state, m_ir, m_irsh;
  logic        m_byp;
  logic [31:0] m_id;

  jtag_tap_core #(
    .IR_WIDTH     (4),
    .IDCODE_VALUE (IDCODE),
    .IR_IDCODE    (4'h1),
    .USER_BASE    (4'h8),
    .NUM_USER     (4)
  ) dut (
    .TCK        (TCK),
    .TRST       (TRST),
    .TMS        (TMS),
    .TDI        (TDI),
    .TDO        (TDO),
    .TDO_EN     (TDO_EN),
    .user_tdo   (user_tdo),
    .user_sel   (user_sel),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .tap_rst    (tap_rst),
    .ir_value   (ir_value),
    .tap_state  (tap_state)
  );

  always #5 TCK = ~TCK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic mdl_reset();
    m_state = 4'hF;
    m_ir    = 4'h1;
    m_irsh  = 4'h0;
    m_byp   = 1'b0;
    m_id    = IDCODE;
  endtask

  task automatic mdl_step(input logic tms, input logic tdi);
    bit is_id, is_user;
    is_id   = (m_ir == 4'h1);
    is_user = (m_ir >= 4'h8) && (m_ir <= 4'hB);
    if (m_state == 4'hE) m_irsh = 4'b0001;
    if (m_state == 4'hA) m_irsh = {tdi, m_irsh[3:1]};
    if (is_id && m_state == 4'h6) m_id = IDCODE;
    if (is_id && m_state == 4'h2) m_id = {tdi, m_id[31:1]};
    if (!is_id && !is_user && m_state == 4'h6) m_byp = 1'b0;
    if (!is_id && !is_user && m_state == 4'h2) m_byp = tdi;
    m_state = tms ? NXT1[m_state] : NXT0[m_state];
    if (m_state == 4'hD) m_ir = m_irsh;
    if (m_state == 4'hF) m_ir = 4'h1;
  endtask

  function automatic logic exp_tdo();
    int idx;
    if (m_state == 4'hA) return m_irsh[0];
    if (m_state != 4'h2) return 1'b0;
    if (m_ir == 4'h1) return m_id[0];
    if (m_ir >= 4'h8 && m_ir <= 4'hB) begin
      idx = int'(m_ir) - 8;
      return user_tdo[idx];
    end
    return m_byp;
  endfunction

  function automatic logic [3:0] exp_sel();
    if (m_ir >= 4'h8 && m_ir <= 4'hB) return 4'b0001 << (m_ir - 4'h8);
    return 4'b0000;
  endfunction

  // One TCK cycle; returns just after the falling edge so TDO/state are settled.
  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    mdl_step(tms, tdi);
    @(negedge TCK);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] val);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick(k == 3, val[k]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    TRST = 1'b1;
    @(negedge TCK);
    #1;
    n_total++; if (tap_state !== 4'hF) $display("FAIL reset_state: got %h want F", tap_state); else n_pass++;
    n_total++; if (ir_value !== 4'h1) $display("FAIL reset_ir: got %h want 1", ir_value); else n_pass++;
    n_total++; if (TDO_EN !== 1'b0 || TDO !== 1'b0) $display("FAIL reset_tdo: got %b%b want 00", TDO_EN, TDO); else n_pass++;
    n_total++; if (tap_rst !== 1'b1) $display("FAIL reset_taprst: got %b want 1", tap_rst); else n_pass++;
    n_total++; if ({user_sel, capture_dr, shift_dr, update_dr} !== 7'b0) $display("FAIL reset_sel_strobes: got %b want 0", {user_sel, capture_dr, shift_dr, update_dr}); else n_pass++;
    TRST = 1'b0;
    mdl_reset();
    tick(1'b0, 1'b0);
    n_total++; if (tap_state !== 4'hC) $display("FAIL reset_to_rti: got %h want C", tap_state); else n_pass++;
    n_total++; if (ir_value !== 4'h1 || TDO_EN !== 1'b0 || tap_rst !== 1'b0) $display("FAIL rti_outputs: got ir=%h en=%b rst=%b want ir=1 en=0 rst=0", ir_value, TDO_EN, tap_rst); else n_pass++;
  endtask

  task automatic test_idcode();
    logic [31:0] got;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    got[0] = TDO;
    n_total++; if (TDO_EN !== 1'b1) $display("FAIL idcode_tdo_en: got %b want 1", TDO_EN); else n_pass++;
    for (int k = 1; k < 32; k++) begin
      tick(1'b0, 1'($urandom));
      got[k] = TDO;
    end
    tick(1'b1, 1'b0);
    n_total++; if (got !== IDCODE) $display("FAIL idcode_stream: got %h want %h", got, IDCODE); else n_pass++;
    n_total++; if (TDO_EN !== 1'b0) $display("FAIL idcode_exit_en: got %b want 0", TDO_EN); else n_pass++;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_bypass();
    logic [3:0] obs;
    logic [7:0] pat, got;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    obs[0] = TDO;
    for (int k = 0; k < 4; k++) begin
      tick(k == 3, 1'b1);
      if (k < 3) obs[k+1] = TDO;
    end
    n_total++; if (obs !== 4'b0001) $display("FAIL ir_capture_stream: got %b want 0001", obs); else n_pass++;
    tick(1'b1, 1'b0);
    n_total++; if (ir_value !== 4'hF || user_sel !== 4'b0) $display("FAIL ir_update_f: got ir=%h sel=%b want F 0000", ir_value, user_sel); else n_pass++;
    for (int p = 0; p < 2; p++) begin
      pat = (p == 0) ? 8'hA5 : 8'($urandom);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      n_total++; if (TDO !== 1'b0) $display("FAIL bypass_first_bit: got %b want 0", TDO); else n_pass++;
      for (int k = 0; k < 8; k++) begin
        tick(1'b0, pat[k]);
        got[k] = TDO;
      end
      tick(1'b1, 1'b0);
      n_total++; if (got !== pat) $display("FAIL bypass_delay: got %h want %h", got, pat); else n_pass++;
      tick(1'b1, 1'b0);
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_user();
    logic [3:0] u;
    load_ir(4'hA);
    n_total++; if (ir_value !== 4'hA || user_sel !== 4'b0100) $display("FAIL user_select: got ir=%h sel=%b want A 0100", ir_value, user_sel); else n_pass++;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n_total++; if (capture_dr !== 1'b1 || shift_dr !== 1'b0) $display("FAIL capture_strobe: got cap=%b sh=%b want 1 0", capture_dr, shift_dr); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      u = 4'($urandom);
      user_tdo = u;
      tick(1'b0, 1'($urandom));
      n_total++; if (TDO !== u[2] || shift_dr !== 1'b1) $display("FAIL user_tdo_follow: got tdo=%b sh=%b want %b 1", TDO, shift_dr, u[2]); else n_pass++;
    end
    tick(1'b1, 1'b0);
    n_total++; if (update_dr !== 1'b0 || shift_dr !== 1'b0) $display("FAIL exit1_strobes: got upd=%b sh=%b want 0 0", update_dr, shift_dr); else n_pass++;
    tick(1'b1, 1'b0);
    n_total++; if (update_dr !== 1'b1) $display("FAIL update_pulse: got %b want 1", update_dr); else n_pass++;
    tick(1'b0, 1'b0);
    n_total++; if (update_dr !== 1'b0) $display("FAIL update_pulse_end: got %b want 0", update_dr); else n_pass++;
    user_tdo = 4'h0;
  endtask

  task automatic test_capture_exit();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    n_total++; if (ir_value !== 4'h1) $display("FAIL capture_exit_update: got %h want 1", ir_value); else n_pass++;
    tick(1'b0, 1'b0);
  endtask

  task automatic test_trst_mid();
    // Abandoned IR shift: active IR must revert to IDCODE, not keep the loaded code.
    load_ir(4'hA);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    TRST = 1'b1;
    #1;
    n_total++; if (ir_value !== 4'h1 || tap_state !== 4'hF) $display("FAIL trst_ir_shift: got ir=%h st=%h want 1 F", ir_value, tap_state); else n_pass++;
    #1;
    TRST = 1'b0;
    mdl_reset();
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int k = 0; k < 9; k++) tick(1'b0, 1'($urandom));
    TMS = 1'b0;
    TRST = 1'b1;
    #1;
    n_total++; if (tap_state !== 4'hF || ir_value !== 4'h1 || TDO_EN !== 1'b0) $display("FAIL trst_mid_dr: got st=%h ir=%h en=%b want F 1 0", tap_state, ir_value, TDO_EN); else n_pass++;
    n_total++; if (update_dr !== 1'b0 || tap_rst !== 1'b1) $display("FAIL trst_mid_strobes: got upd=%b rst=%b want 0 1", update_dr, tap_rst); else n_pass++;
    #1;
    TRST = 1'b0;
    mdl_reset();
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0);
      n_total++; if (update_dr !== 1'b0) $display("FAIL trst_no_update: got %b want 0", update_dr); else n_pass++;
    end
  endtask

  task automatic test_pause();
    logic [31:0] got;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    got[0] = TDO;
    for (int k = 1; k < 16; k++) begin
      tick(1'b0, 1'($urandom));
      got[k] = TDO;
    end
    tick(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'($urandom));
    n_total++; if (tap_state !== 4'h3) $display("FAIL pause_dr_state: got %h want 3", tap_state); else n_pass++;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    got[16] = TDO;
    for (int k = 17; k < 32; k++) begin
      tick(1'b0, 1'($urandom));
      got[k] = TDO;
    end
    tick(1'b1, 1'b0);
    n_total++; if (got !== IDCODE) $display("FAIL pause_resume_stream: got %h want %h", got, IDCODE); else n_pass++;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n_total++; if (tap_state !== 4'hB) $display("FAIL pause_ir_state: got %h want B", tap_state); else n_pass++;
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
    n_total++; if (tap_state !== 4'hF) $display("FAIL pause_ir_to_tlr: got %h want F", tap_state); else n_pass++;
    tick(1'b0, 1'b0);
  endtask

  task automatic test_random_walk();
    for (int step = 0; step < 400; step++) begin
      user_tdo = 4'($urandom);
      tick(1'($urandom), 1'($urandom));
      n_total++; if (tap_state !== m_state) $display("FAIL rand_state[%0d]: got %h want %h", step, tap_state, m_state); else n_pass++;
      n_total++; if (TDO !== exp_tdo()) $display("FAIL rand_tdo[%0d]: got %b want %b", step, TDO, exp_tdo()); else n_pass++;
      n_total++; if (TDO_EN !== (m_state == 4'h2 || m_state == 4'hA)) $display("FAIL rand_tdo_en[%0d]: got %b want %b", step, TDO_EN, (m_state == 4'h2 || m_state == 4'hA)); else n_pass++;
      n_total++; if (ir_value !== m_ir || user_sel !== exp_sel()) $display("FAIL rand_ir[%0d]: got %h/%b want %h/%b", step, ir_value, user_sel, m_ir, exp_sel()); else n_pass++;
      if (step % 64 == 63) begin
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
        n_total++; if (tap_state !== 4'hF) $display("FAIL rand_sync_reset[%0d]: got %h want F", step, tap_state); else n_pass++;
      end
    end
  endtask

  initial begin
    mdl_reset();
    test_reset();
    test_idcode();
    test_bypass();
    test_user();
    test_capture_exit();
    test_trst_mid();
    test_pause();
    test_random_walk();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
